// File: rtl/key_debouncer_if.sv
// Push-button bundle: raw KEY input and the debounced level/pulse/counter outputs.
interface key_debouncer_if;
  logic       KEY;
  logic       key_level;
  logic       key_press;
  logic       key_release;
  logic [7:0] press_count;

  modport master (output KEY, input key_level, input key_press, input key_release,
                  input press_count);
  modport slave  (input KEY, output key_level, output key_press, output key_release,
                  output press_count);
endinterface

// File: rtl/key_debouncer.sv
// Synchronises and debounces one raw push-button; emits a clean level, press/release
// pulses and an 8-bit modulo press counter.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic           CLOCK_50,
  input  logic           RESET,
  key_debouncer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RELEASED_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_e;

  logic             s1_q, s2_q;
  logic             pressed_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [7:0]       count_q, count_d;

  // Two-flop synchroniser, reset to the released level so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      s1_q <= RELEASED_LVL;
      s2_q <= RELEASED_LVL;
    end else begin
      s1_q <= bus.KEY;
      s2_q <= s1_q;
    end
  end

  assign pressed_s = ACTIVE_LOW ? ~s2_q : s2_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  // Counter restarts on every state change; a reversal during a wait rejects the edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      ST_RELEASED: begin
        if (pressed_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, active-low key.
module tb_key_debouncer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  key_debouncer_if bus ();

  key_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.KEY = 1'b1;
    rst     = 1'b1;
    #2;
    checks++;
    if (bus.key_level !== 1'b0 || bus.key_press !== 1'b0 || bus.key_release !== 1'b0 ||
        bus.press_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: level=%b press=%b release=%b count=%0d, want all 0",
               bus.key_level, bus.key_press, bus.key_release, bus.press_count);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (bus.key_level !== 1'b0 || bus.key_press !== 1'b0 || bus.key_release !== 1'b0 ||
          bus.press_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: level=%b press=%b release=%b count=%0d, want all 0",
                 i, bus.key_level, bus.key_press, bus.key_release, bus.press_count);
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 5; i++) begin
        bus.KEY = (i < 3) ? 1'b0 : 1'b1;
        tick();
        checks++;
        if (bus.key_press !== 1'b0 || bus.key_level !== 1'b0) begin
          errors++;
          $display("FAIL bounce r%0d c%0d: press=%b level=%b, want 0 0",
                   r, i, bus.key_press, bus.key_level);
        end
      end
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.press_count !== 8'd0) begin
      errors++;
      $display("FAIL bounce_count: got %0d want 0", bus.press_count);
    end
  endtask

  task automatic test_clean_press();
    bus.KEY = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (bus.key_press !== (i == 7) || bus.key_level !== (i >= 7) ||
          bus.press_count !== ((i >= 7) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL press edge %0d: press=%b level=%b count=%0d, want %b %b %0d",
                 i, bus.key_press, bus.key_level, bus.press_count,
                 (i == 7), (i >= 7), (i >= 7) ? 1 : 0);
      end
    end
  endtask

  task automatic test_release();
    bus.KEY = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (bus.key_release !== (i == 7) || bus.key_level !== (i < 7) ||
          bus.key_press !== 1'b0 || bus.press_count !== 8'd1) begin
        errors++;
        $display("FAIL release edge %0d: release=%b level=%b press=%b count=%0d, want %b %b 0 1",
                 i, bus.key_release, bus.key_level, bus.key_press, bus.press_count,
                 (i == 7), (i < 7));
      end
    end
  endtask

  task automatic test_wrap();
    int presses;
    int releases;
    int both;
    presses  = 0;
    releases = 0;
    both     = 0;
    bus.KEY  = 1'b1;
    apply_reset();
    for (int p = 0; p < 256; p++) begin
      bus.KEY = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.key_press === 1'b1) presses++;
        if (bus.key_press === 1'b1 && bus.key_release === 1'b1) both++;
      end
      if (p == 254) begin
        checks++;
        if (bus.press_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d want 255", bus.press_count);
        end
      end
      bus.KEY = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.key_release === 1'b1) releases++;
        if (bus.key_press === 1'b1 && bus.key_release === 1'b1) both++;
      end
    end
    checks++;
    if (presses != 256) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d want 256", presses);
    end
    checks++;
    if (releases != 256) begin
      errors++;
      $display("FAIL wrap_releases: got %0d want 256", releases);
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL wrap_exclusive: got %0d overlapping cycles want 0", both);
    end
    checks++;
    if (bus.press_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 0", bus.press_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    bus.KEY = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.key_level !== 1'b0 || bus.key_press !== 1'b0) begin
      errors++;
      $display("FAIL midwait_pre: level=%b press=%b want 0 0", bus.key_level, bus.key_press);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (bus.key_level !== 1'b0 || bus.key_press !== 1'b0 || bus.key_release !== 1'b0 ||
        bus.press_count !== 8'd0) begin
      errors++;
      $display("FAIL midwait_reset: level=%b press=%b release=%b count=%0d want all 0",
               bus.key_level, bus.key_press, bus.key_release, bus.press_count);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (bus.key_press !== (i == 7) || bus.key_level !== (i >= 7) ||
          bus.press_count !== ((i >= 7) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL midwait edge %0d: press=%b level=%b count=%0d, want %b %b %0d",
                 i, bus.key_press, bus.key_level, bus.press_count,
                 (i == 7), (i >= 7), (i >= 7) ? 1 : 0);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.KEY = 1'b1;
    test_reset();
    test_bounce();
    test_clean_press();
    test_release();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
